md_sched: RTL and testbench

Sequencing controller for the shared multiply/divide resource of the five-stage pipeline. Accepts one HI/LO-class operation per cycle from the E stage. Runs multi-cycle mult/div operations on an internal busy counter and commits results to HI/LO. Drives a stall request that the hazard unit ORs into its D-stage `delay` so that no HI/LO-class instruction leaves D while the unit is occupied.

---
 rtl/md_pkg.sv | 28 ++
 rtl/md_core.sv | 54 +++++
 rtl/md_sched.sv | 102 ++++++++++
 tb/tb_md_sched.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// FSM states and default latencies.
package md_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    // Multi-cycle ops occupy the unit; moves to HI/LO complete in one cycle.
    function automatic logic is_mc(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_core.sv
// Combinational 64-bit mult/div result generator, including the
// divide-by-zero and signed-overflow corner cases.
module md_core
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] dvs;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic        div0;
    logic        ovf;

    always_comb begin
        div0 = (b == 32'd0);
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        // Keep the dividers away from x/0 and the unrepresentable quotient.
        dvs  = (div0 || ovf) ? 32'd1 : b;

        // Low 64 bits of sign-extended operands give the signed product.
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};
        q_s    = $unsigned($signed(a) / $signed(dvs));
        r_s    = $unsigned($signed(a) % $signed(dvs));
        q_u    = a / dvs;
        r_u    = a % dvs;

        {res_hi, res_lo} = 64'd0;
        case (op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                if (div0)     {res_hi, res_lo} = {a, 32'hFFFF_FFFF};
                else if (ovf) {res_hi, res_lo} = {32'd0, 32'h8000_0000};
                else          {res_hi, res_lo} = {r_s, q_s};
            end
            OP_DIVU: begin
                if (div0)     {res_hi, res_lo} = {a, 32'hFFFF_FFFF};
                else          {res_hi, res_lo} = {r_u, q_u};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Sequencer for the shared mult/div unit: latches results, counts out the
// operation latency, commits to HI/LO and requests D-stage stalls.
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_d,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);

    localparam int CW = $clog2(DIV_CYCLES + 1);
    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   res_hi_q, res_hi_d;
    logic [31:0]   res_lo_q, res_lo_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   core_hi;
    logic [31:0]   core_lo;
    logic          start_mc;

    md_core u_core (
        .op     (op),
        .a      (a),
        .b      (b),
        .res_hi (core_hi),
        .res_lo (core_lo)
    );

    assign start_mc = start && is_mc(op);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start_mc) begin
                    res_hi_d = core_hi;
                    res_lo_d = core_lo;
                    cnt_d    = (op == OP_MULT || op == OP_MULTU) ? MULT_CNT : DIV_CNT;
                    state_d  = ST_BUSY;
                end else if (start && op == OP_MTHI) begin
                    hi_d = a;
                end else if (start && op == OP_MTLO) begin
                    lo_d = a;
                end
            end
            ST_BUSY: begin
                // Any start seen here is dropped; the hazard unit keeps it from happening.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    hi_d    = res_hi_q;
                    lo_d    = res_lo_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q == ST_BUSY);
    assign stall = !reset && md_d && (busy || start_mc);

endmodule

// File: tb/tb_md_sched.sv
// Directed self-checking bench for md_sched with hand-computed HI/LO results.
module tb_md_sched;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_d;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .md_d  (md_d),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .stall (stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue a mult/div in the current cycle and follow it to commit.
    task automatic run_mc(input string tag, input logic [2:0] o, input logic [31:0] ia,
                          input logic [31:0] ib, input int n, input logic dd,
                          input logic [31:0] eh, input logic [31:0] el);
        md_d  = dd;
        start = 1'b1;
        op    = o;
        a     = ia;
        b     = ib;
        #1;
        chk({tag, "_stall_T"}, {31'd0, stall}, {31'd0, dd});
        tick;
        start = 1'b0;
        op    = OP_NONE;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_stall"}, {31'd0, stall}, {31'd0, dd});
            chk({tag, "_hi_hold"}, hi, m_hi);
            tick;
        end
        m_hi = eh;
        m_lo = el;
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        md_d = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd0;
        b     = 32'd0;
        md_d  = 1'b1;
        tick;
        tick;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        start = 1'b0;
        op    = OP_NONE;
        md_d  = 1'b0;
        reset = 1'b0;
        tick;

        run_mc("mult", OP_MULT, 32'hFFFF_FFFD, 32'd5, 5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_mc("divu", OP_DIVU, 32'd7, 32'd2, 10, 1'b0, 32'd1, 32'd3);
        run_mc("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_mc("div0", OP_DIV, 32'd9, 32'd0, 10, 1'b0, 32'd9, 32'hFFFF_FFFF);
        run_mc("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 32'd0, 32'h8000_0000);
        run_mc("multu_stall", OP_MULTU, 32'd2, 32'd3, 5, 1'b1, 32'd0, 32'd6);

        // NONE with start does nothing
        start = 1'b1; op = OP_NONE; a = 32'h5555_5555;
        tick;
        start = 1'b0;
        chk("none_busy", {31'd0, busy}, 32'd0);
        chk("none_hi", hi, m_hi);
        chk("none_lo", lo, m_lo);

        start = 1'b1; op = OP_MTLO; a = 32'h0000_1234;
        tick;
        start = 1'b0; op = OP_NONE;
        chk("mtlo_lo", lo, 32'h0000_1234);
        chk("mtlo_hi", hi, m_hi);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        start = 1'b1; op = OP_MTHI; a = 32'hABCD_0001;
        tick;
        start = 1'b0; op = OP_NONE;
        chk("mthi_hi", hi, 32'hABCD_0001);
        chk("mthi_lo", lo, 32'h0000_1234);

        // Reset in cycle T+4 of a divide: aborted result (lo=14, hi=2) must never land
        start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
        tick;
        start = 1'b0; op = OP_NONE;
        tick;
        tick;
        tick;
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        tick;
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("abort_quiet_lo", lo, 32'd0);
            chk("abort_quiet_busy", {31'd0, busy}, 32'd0);
        end
        run_mc("mult_after", OP_MULT, 32'd6, 32'd7, 5, 1'b0, 32'd0, 32'd42);

        // MTHI arriving while busy is dropped; 0x10000 * 0x10000 = 2^32
        start = 1'b1; op = OP_MULT; a = 32'h0001_0000; b = 32'h0001_0000;
        tick;
        start = 1'b1; op = OP_MTHI; a = 32'hDEAD_BEEF;
        tick;
        start = 1'b0; op = OP_NONE;
        chk("mthi_busy_hi", hi, 32'd0);
        chk("mthi_busy_busy", {31'd0, busy}, 32'd1);
        tick;
        tick;
        tick;
        chk("mthi_busy_last", {31'd0, busy}, 32'd1);
        tick;
        chk("mthi_busy_done", {31'd0, busy}, 32'd0);
        chk("mthi_busy_rhi", hi, 32'd1);
        chk("mthi_busy_rlo", lo, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
